// File: rtl/alu_control_md_if.sv
// Core-side bundle for alu_control_md: decode inputs, operands, ALU code,
// multiply/divide stall/busy, HI/LO and the sequencer state for observation.
interface alu_control_md_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic [5:0]       opcode;
  logic             issue;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       alu_ctrl;
  logic             md_stall;
  logic             md_busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;
  logic [2:0]       md_state;

  // Handshake: an MD op is taken at the rising edge where issue=1 and
  // md_stall=0; while md_stall=1 the core holds issue/funct/operands unchanged.
  modport master (
    output aluop, funct, opcode, issue, src_a, src_b,
    input  alu_ctrl, md_stall, md_busy, hi, lo, mf_data, md_state
  );

  modport slave (
    input  aluop, funct, opcode, issue, src_a, src_b,
    output alu_ctrl, md_stall, md_busy, hi, lo, mf_data, md_state
  );
endinterface

// File: rtl/alu_control_md.sv
// ALU-control decoder plus iterative multiply/divide sequencer with HI/LO.
// Optional MULDIV_EARLY_OUT_EN: multiply ends once the remaining multiplier bits are zero.
module alu_control_md #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_control_md_if.slave    md_if
);
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;

  logic [3:0]         alu_ctrl;
  logic               is_md, op_mult, op_div, op_mthi, op_mtlo, op_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_sum, prod_fix;
  logic [WIDTH:0]     rem_shift, rem_sub, rem_next;
  logic               rem_ge;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    alu_ctrl = 4'b0010;
    case (md_if.aluop)
      2'b00: alu_ctrl = 4'b0010;
      2'b01: alu_ctrl = 4'b0110;
      2'b11: begin
        case (md_if.opcode)
          6'b001101: alu_ctrl = 4'b0001;
          6'b001100: alu_ctrl = 4'b0000;
          6'b001010: alu_ctrl = 4'b0111;
          default:   alu_ctrl = 4'b0010;
        endcase
      end
      default: begin
        case (md_if.funct)
          6'b100000, 6'b100001: alu_ctrl = 4'b0010;
          6'b100010, 6'b100011: alu_ctrl = 4'b0110;
          6'b100100:            alu_ctrl = 4'b0000;
          6'b100101:            alu_ctrl = 4'b0001;
          6'b100111:            alu_ctrl = 4'b0011;
          6'b101010:            alu_ctrl = 4'b0111;
          6'b000000:            alu_ctrl = 4'b1000;
          6'b000010:            alu_ctrl = 4'b1001;
          6'b000011:            alu_ctrl = 4'b1010;
          default:              alu_ctrl = 4'b0010;
        endcase
      end
    endcase
  end

  always_comb begin
    is_md   = 1'b0;
    op_mult = 1'b0;
    op_div  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    if (md_if.issue && md_if.aluop == 2'b10) begin
      case (md_if.funct)
        6'b011000, 6'b011001: begin is_md = 1'b1; op_mult = 1'b1; end
        6'b011010, 6'b011011: begin is_md = 1'b1; op_div  = 1'b1; end
        6'b010000, 6'b010010: is_md = 1'b1;
        6'b010001:            begin is_md = 1'b1; op_mthi = 1'b1; end
        6'b010011:            begin is_md = 1'b1; op_mtlo = 1'b1; end
        default:              is_md = 1'b0;
      endcase
    end
  end

  // Even funct codes (mult/div) are the signed variants.
  assign op_signed = ~md_if.funct[0];
  assign a_neg     = op_signed & md_if.src_a[WIDTH-1];
  assign b_neg     = op_signed & md_if.src_b[WIDTH-1];
  assign a_mag     = a_neg ? -md_if.src_a : md_if.src_a;
  assign b_mag     = b_neg ? -md_if.src_b : md_if.src_b;

  assign mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Restoring divide: acc_q[WIDTH-1:0] is the partial remainder, mplier_q
  // shifts the dividend out of its top while quotient bits enter at the bottom.
  assign rem_shift = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, mcand_q[WIDTH-1:0]};
  assign rem_sub   = rem_shift - {1'b0, mcand_q[WIDTH-1:0]};
  assign rem_next  = rem_ge ? rem_sub : rem_shift;

  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign quot_fix  = neg_q ? -mplier_q : mplier_q;
  assign rem_fix   = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    case (state_q)
      S_IDLE: begin
        if (op_mult) begin
          acc_d     = '0;
          mcand_d   = {{WIDTH{1'b0}}, a_mag};
          mplier_d  = b_mag;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = 1'b0;
          is_div_d  = 1'b0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = S_MUL;
        end else if (op_div) begin
          if (md_if.src_b == '0) begin
            hi_d    = md_if.src_a;
            lo_d    = '1;
            state_d = S_DONE;
          end else begin
            acc_d     = '0;
            mcand_d   = {{WIDTH{1'b0}}, b_mag};
            mplier_d  = a_mag;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            is_div_d  = 1'b1;
            cnt_d     = CNT_W'(WIDTH);
            state_d   = S_DIV;
          end
        end else if (op_mthi) begin
          hi_d = md_if.src_a;
        end else if (op_mtlo) begin
          lo_d = md_if.src_a;
        end
      end
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
`ifdef MULDIV_EARLY_OUT_EN
        if (cnt_q == CNT_W'(1) || mplier_d == '0) state_d = S_FIX;
`else
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
`endif
      end
      S_DIV: begin
        acc_d    = {{(WIDTH-1){1'b0}}, rem_next};
        mplier_d = {mplier_q[WIDTH-2:0], rem_ge};
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        cnt_d   = '0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  assign md_if.alu_ctrl = alu_ctrl;
  assign md_if.md_stall = is_md && (state_q != S_IDLE);
  assign md_if.md_busy  = (state_q != S_IDLE);
  assign md_if.hi       = hi_q;
  assign md_if.lo       = lo_q;
  assign md_if.mf_data  = (md_if.funct == 6'b010000) ? hi_q : lo_q;
  assign md_if.md_state = state_q;
endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
Parametrised successor to the single-cycle ALU control decoder. It keeps combinational ALU-control decode from aluop/funct/opcode, widened to a 4-bit control code with shift and nor encodings. It adds an iterative multiply/divide sequencer with HI/LO registers and a stall handshake. Sits between the main control unit and the ALU in the MIPS-lite datapath; the core stalls on md_stall.

Parameters:
WIDTH, 32, operand and HI/LO width (even, >=8)
CNT_W, 6, iteration counter width (must satisfy 2**CNT_W > WIDTH)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
aluop  in  2  from main control: 00 add, 01 sub, 10 R-type (funct decode), 11 I-type (opcode decode)
funct  in  6  instruction[5:0]
opcode  in  6  instruction[31:26]
issue  in  1  instruction in decode is valid this cycle
src_a  in  WIDTH  rs value
src_b  in  WIDTH  rt value
alu_ctrl  out  4  ALU operation code
md_stall  out  1  core must hold the current instruction
md_busy  out  1  sequencer not IDLE
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
mf_data  out  WIDTH  selected HI/LO for mfhi/mflo

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; hi=0; lo=0; counter=0; md_busy=0; md_stall=0. alu_ctrl is combinational and has no reset value.
- alu_ctrl decode, combinational, priority top-down:
  - aluop=00 -> 0010 add.
  - aluop=01 -> 0110 sub.
  - aluop=11 -> by opcode: 001101 ori -> 0001; 001100 andi -> 0000; 001010 slti -> 0111; otherwise 0010.
  - aluop=10 -> by funct: 100000/100001 add -> 0010; 100010/100011 sub -> 0110; 100100 and -> 0000; 100101 or -> 0001; 100111 nor -> 0011; 101010 slt -> 0111; 000000 sll -> 1000; 000010 srl -> 1001; 000011 sra -> 1010; otherwise 0010.
- MD ops are recognised only when aluop=10 and issue=1: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010, mthi 010001, mtlo 010011.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE + mult/multu:
  - Latch operand magnitudes; the signed flag is set for mult.
  - Go to MUL, counter=WIDTH.
  - Shift-add 1 bit per cycle.
  - At counter=0 go to FIX.
- IDLE + div/divu:
  - divisor=0: go directly to DONE with hi=src_a, lo=all ones.
  - Otherwise go to DIV, counter=WIDTH.
  - Restoring division, 1 quotient bit per cycle, then FIX.
- FIX (1 cycle): apply two's-complement sign correction.
  - mult: negate the 2*WIDTH product if the operand signs differ.
  - div: the quotient follows the same rule; the remainder takes the sign of the dividend.
  - Write hi/lo, then go to DONE.
- DONE (1 cycle): then IDLE.
- Latency: mult/div result visible on hi/lo the cycle after FIX, i.e. WIDTH+2 cycles after issue; divide-by-zero takes 1 cycle.
- md_stall=1 while state != IDLE and issue=1 with any MD op. A non-MD instruction never stalls, so independent instructions overlap with the sequencer.
- md_stall is combinational from state, issue and funct; it is never asserted in IDLE.
- mthi/mtlo in IDLE: write src_a to hi/lo at the clock edge, no stall.
- mf_data = hi if funct=010000, else lo; valid when md_stall=0.
- A new MD op issued the same cycle DONE exits is stalled one cycle. It is accepted only in IDLE.
- Reset asserted mid-operation aborts immediately to IDLE and clears hi/lo.
- Signed edge case: mult of (-2^(WIDTH-1)) x (-2^(WIDTH-1)) yields 2^(2*WIDTH-2) exactly.
- Signed edge case: div of (-2^(WIDTH-1)) / -1 yields lo=-2^(WIDTH-1), hi=0 (wrap, no trap).

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, jump to FIX at once. Latency becomes 2 + (index of the highest set bit + 1) cycles; multiplier=0 gives FIX on the next cycle.
- Undefined: fixed WIDTH-cycle multiply.
- Division latency is unchanged in both cases.

Test Plan:
- Decode sweep: aluop=10 with funct 100111 -> alu_ctrl=0011; 000011 -> 1010; aluop=11 with opcode 001101 -> 0001; aluop=01 -> 0110.
- mult src_a=0xFFFFFFFE (-2), src_b=3 -> after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA; md_busy high for 34 cycles.
- divu 100/7 -> lo=14, hi=2. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div by 0 with src_a=5 -> hi=5, lo=0xFFFFFFFF after 1 cycle.
- mflo issued 3 cycles after mult -> md_stall=1 until IDLE, then mf_data = product low word. An add issued during MUL -> md_stall=0, alu_ctrl=0010.
- rst_n pulsed low mid-DIV (counter=10) -> state IDLE, hi=lo=0, md_busy=0 asynchronously. The next divu completes correctly.
- With MULDIV_EARLY_OUT_EN: multu src_b=1 -> done in 3 cycles, lo=src_a. Without the macro -> 34 cycles, same result.
